// File: rtl/vending_pkg.sv
// Shared types and constants for the vending machine change-return path.
package vending_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PLAN,
      ST_EJECT_F,
      ST_EJECT_S,
      ST_WAIT,
      ST_DONE,
      ST_FAULT
   } chg_state_t;

   localparam int CHANGE_W = 4;

   localparam logic [CHANGE_W-1:0] FLORIN_VALUE   = CHANGE_W'(2);
   localparam logic [CHANGE_W-1:0] SHILLING_VALUE = CHANGE_W'(1);

endpackage

// File: rtl/coin_inventory.sv
// Saturating coin stock counter for one denomination; a refill and a
// dispense landing in the same cycle cancel out.
module coin_inventory #(
   parameter  int COIN_MAX = 15,
   localparam int CW       = $clog2(COIN_MAX + 1)
) (
   input  logic          clock_50MHz,
   input  logic          sync_Reset_n,
   input  logic          inc_i,
   input  logic          dec_i,
   output logic [CW-1:0] count_o
);

   localparam logic [CW-1:0] MAX_COUNT = CW'(COIN_MAX);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && !dec_i && (count_q < MAX_COUNT)) begin
         count_d = count_q + CW'(1);
      end else if (dec_i && !inc_i && (count_q != '0)) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clock_50MHz) begin
      if (!sync_Reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/change_dispenser_ctrl.sv
// Change-return sequencer: pays out greedy florin-first, one coin per hopper
// handshake, tracks stock, and latches a fault if the hopper stops responding.
module change_dispenser_ctrl
   import vending_pkg::*;
#(
   parameter int PULSE_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int COIN_MAX       = 15
) (
   input  logic                             clock_50MHz,
   input  logic                             sync_Reset_n,
   input  logic                             change_req,
   input  logic [CHANGE_W-1:0]              change_amount,
   input  logic                             eject_done,
   input  logic                             refill_florin,
   input  logic                             refill_shilling,
   output logic                             change_ack,
   output logic                             florin_Change,
   output logic                             shilling_Change,
   output logic                             busy,
   output logic                             done,
   output logic                             short_change,
   output logic                             fault,
   output logic [CHANGE_W-1:0]              remaining,
   output logic [$clog2(COIN_MAX+1)-1:0]    florin_count,
   output logic [$clog2(COIN_MAX+1)-1:0]    shilling_count
);

   localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
   localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT_CYCLES - 1);

   chg_state_t          state_q;
   logic [CHANGE_W-1:0] remaining_q;
   logic [PW-1:0]       pulseCnt_q;
   logic [TW-1:0]       waitCnt_q;
   logic                coinIsFlorin_q;
   logic                ack_q;
   logic                florinStrobe_q;
   logic                shillingStrobe_q;
   logic                busy_q;
   logic                done_q;
   logic                shortChange_q;
   logic                fault_q;

   logic coinDropped;
   logic decFlorin;
   logic decShilling;

   assign coinDropped = (state_q == ST_WAIT) && eject_done;
   assign decFlorin   = coinDropped && coinIsFlorin_q;
   assign decShilling = coinDropped && !coinIsFlorin_q;

   coin_inventory #(.COIN_MAX(COIN_MAX)) u_florinStock (
      .clock_50MHz  (clock_50MHz),
      .sync_Reset_n (sync_Reset_n),
      .inc_i        (refill_florin),
      .dec_i        (decFlorin),
      .count_o      (florin_count)
   );

   coin_inventory #(.COIN_MAX(COIN_MAX)) u_shillingStock (
      .clock_50MHz  (clock_50MHz),
      .sync_Reset_n (sync_Reset_n),
      .inc_i        (refill_shilling),
      .dec_i        (decShilling),
      .count_o      (shilling_count)
   );

   // PLAN sees stock already updated by the previous coin, so a florin is
   // only chosen when both the amount and the stock allow it.
   always_ff @(posedge clock_50MHz) begin
      if (!sync_Reset_n) begin
         state_q          <= ST_IDLE;
         remaining_q      <= '0;
         pulseCnt_q       <= '0;
         waitCnt_q        <= '0;
         coinIsFlorin_q   <= 1'b0;
         ack_q            <= 1'b0;
         florinStrobe_q   <= 1'b0;
         shillingStrobe_q <= 1'b0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         shortChange_q    <= 1'b0;
         fault_q          <= 1'b0;
      end else begin
         ack_q  <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (change_req) begin
                  state_q       <= ST_PLAN;
                  remaining_q   <= change_amount;
                  ack_q         <= 1'b1;
                  busy_q        <= 1'b1;
                  shortChange_q <= 1'b0;
               end
            end
            ST_PLAN: begin
               if (remaining_q == '0) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end else if ((remaining_q >= FLORIN_VALUE) && (florin_count != '0)) begin
                  state_q        <= ST_EJECT_F;
                  florinStrobe_q <= 1'b1;
                  pulseCnt_q     <= '0;
                  coinIsFlorin_q <= 1'b1;
               end else if (shilling_count != '0) begin
                  state_q          <= ST_EJECT_S;
                  shillingStrobe_q <= 1'b1;
                  pulseCnt_q       <= '0;
                  coinIsFlorin_q   <= 1'b0;
               end else begin
                  state_q       <= ST_DONE;
                  done_q        <= 1'b1;
                  shortChange_q <= 1'b1;
               end
            end
            ST_EJECT_F, ST_EJECT_S: begin
               if (pulseCnt_q == PULSE_LAST) begin
                  florinStrobe_q   <= 1'b0;
                  shillingStrobe_q <= 1'b0;
                  waitCnt_q        <= '0;
                  state_q          <= ST_WAIT;
               end else begin
                  pulseCnt_q <= pulseCnt_q + PW'(1);
               end
            end
            ST_WAIT: begin
               if (eject_done) begin
                  remaining_q <= remaining_q - (coinIsFlorin_q ? FLORIN_VALUE : SHILLING_VALUE);
                  state_q     <= ST_PLAN;
               end else if (waitCnt_q == WAIT_LAST) begin
                  fault_q <= 1'b1;
                  state_q <= ST_FAULT;
               end else begin
                  waitCnt_q <= waitCnt_q + TW'(1);
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            ST_FAULT: begin
               state_q <= ST_FAULT;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign change_ack      = ack_q;
   assign florin_Change   = florinStrobe_q;
   assign shilling_Change = shillingStrobe_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign short_change    = shortChange_q;
   assign fault           = fault_q;
   assign remaining       = remaining_q;

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Self-checking bench for change_dispenser_ctrl: directed scenarios plus a
// randomized soak, all compared every cycle against a behavioural model.
module tb_change_dispenser_ctrl;

   localparam int PULSE   = 4;
   localparam int TIMEOUT = 1000;
   localparam int CMAX    = 15;

   logic       clk;
   logic       rstN;
   logic       changeReq;
   logic [3:0] changeAmount;
   logic       ejectDone;
   logic       refillF;
   logic       refillS;
   logic       changeAck;
   logic       florinChange;
   logic       shillingChange;
   logic       busy;
   logic       done;
   logic       shortChange;
   logic       fault;
   logic [3:0] remaining;
   logic [3:0] florinCount;
   logic [3:0] shillingCount;

   int checks = 0;
   int errors = 0;
   bit checkEn = 0;

   change_dispenser_ctrl #(
      .PULSE_CYCLES   (PULSE),
      .TIMEOUT_CYCLES (TIMEOUT),
      .COIN_MAX       (CMAX)
   ) dut (
      .clock_50MHz     (clk),
      .sync_Reset_n    (rstN),
      .change_req      (changeReq),
      .change_amount   (changeAmount),
      .eject_done      (ejectDone),
      .refill_florin   (refillF),
      .refill_shilling (refillS),
      .change_ack      (changeAck),
      .florin_Change   (florinChange),
      .shilling_Change (shillingChange),
      .busy            (busy),
      .done            (done),
      .short_change    (shortChange),
      .fault           (fault),
      .remaining       (remaining),
      .florin_count    (florinCount),
      .shilling_count  (shillingCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural view of a payout: a transaction is a list of coin phases
   // (strobe for PULSE cycles, then wait for the hopper), bracketed by a
   // decision step after every coin and a single finishing cycle.
   int mAck, mDone, mShort, mFault, mBusy, mRem, mFl, mSh;
   int mStrobeF, mStrobeS, mPulseLeft, mWaiting, mWaitCycles;
   int mDecide, mFinish, mCoinIsFlorin;

   function automatic int nextStock(input int c, input int inc, input int dec);
      if (inc != 0 && dec == 0) return (c < CMAX) ? c + 1 : c;
      if (dec != 0 && inc == 0) return (c > 0) ? c - 1 : c;
      return c;
   endfunction

   always @(posedge clk) begin : model
      int decF;
      int decS;
      decF = 0;
      decS = 0;
      if (!rstN) begin
         mAck = 0; mDone = 0; mShort = 0; mFault = 0; mBusy = 0; mRem = 0;
         mFl = 0; mSh = 0; mStrobeF = 0; mStrobeS = 0; mPulseLeft = 0;
         mWaiting = 0; mWaitCycles = 0; mDecide = 0; mFinish = 0; mCoinIsFlorin = 0;
      end else begin
         mAck  = 0;
         mDone = 0;
         if (mFault != 0) begin
            mBusy = 1;
         end else if (mBusy == 0) begin
            if (changeReq) begin
               mRem = int'(changeAmount); mAck = 1; mBusy = 1; mShort = 0; mDecide = 1;
            end
         end else if (mDecide != 0) begin
            mDecide = 0;
            if (mRem == 0) begin
               mDone = 1; mFinish = 1;
            end else if (mRem >= 2 && mFl > 0) begin
               mStrobeF = 1; mPulseLeft = PULSE; mCoinIsFlorin = 1;
            end else if (mSh > 0) begin
               mStrobeS = 1; mPulseLeft = PULSE; mCoinIsFlorin = 0;
            end else begin
               mDone = 1; mShort = 1; mFinish = 1;
            end
         end else if (mFinish != 0) begin
            mFinish = 0; mBusy = 0;
         end else if (mPulseLeft > 0) begin
            mPulseLeft--;
            if (mPulseLeft == 0) begin
               mStrobeF = 0; mStrobeS = 0; mWaiting = 1; mWaitCycles = 0;
            end
         end else if (mWaiting != 0) begin
            if (ejectDone) begin
               mWaiting = 0; mDecide = 1;
               if (mCoinIsFlorin != 0) begin mRem -= 2; decF = 1; end
               else begin mRem -= 1; decS = 1; end
            end else begin
               mWaitCycles++;
               if (mWaitCycles == TIMEOUT) begin mWaiting = 0; mFault = 1; end
            end
         end
         mFl = nextStock(mFl, int'(refillF), decF);
         mSh = nextStock(mSh, int'(refillS), decS);
      end
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("change_ack", int'(changeAck), mAck);
         checkOutput("done", int'(done), mDone);
         checkOutput("busy", int'(busy), mBusy);
         checkOutput("short_change", int'(shortChange), mShort);
         checkOutput("fault", int'(fault), mFault);
         checkOutput("florin_Change", int'(florinChange), mStrobeF);
         checkOutput("shilling_Change", int'(shillingChange), mStrobeS);
         checkOutput("remaining", int'(remaining), mRem);
         checkOutput("florin_count", int'(florinCount), mFl);
         checkOutput("shilling_count", int'(shillingCount), mSh);
      end
   end

   task automatic applyStimulus(input logic req, input logic [3:0] amt, input logic ed,
                                input logic rf, input logic rs);
      changeReq    = req;
      changeAmount = amt;
      ejectDone    = ed;
      refillF      = rf;
      refillS      = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rstN = 1'b0;
      applyStimulus(0, 4'd0, 0, 0, 0);
      checkEn = 1;
      applyStimulus(0, 4'd0, 0, 0, 0);
      rstN = 1'b1;
   endtask

   // Requests an amount and answers every hopper wait immediately.
   task automatic runTxn(input logic [3:0] amt, output int fCyc, output int sCyc,
                         output int doneCnt);
      bit finished;
      fCyc = 0; sCyc = 0; doneCnt = 0; finished = 0;
      applyStimulus(1, amt, 0, 0, 0);
      for (int i = 0; i < 300 && !finished; i++) begin
         applyStimulus(0, 4'd0, logic'(mWaiting != 0), 0, 0);
         fCyc    += int'(florinChange);
         sCyc    += int'(shillingChange);
         doneCnt += int'(done);
         if (mBusy == 0) finished = 1;
      end
      checkOutput("txn_completes", int'(finished), 1);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int fCyc, sCyc, doneCnt, cyc, rate;
      bit seen;
      changeReq = 0; changeAmount = 0; ejectDone = 0; refillF = 0; refillS = 0;
      rstN = 1'b0;

      doReset();
      checkOutput("reset_remaining", int'(remaining), 0);
      checkOutput("reset_florins", int'(florinCount), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_fault", int'(fault), 0);

      $display("[TB] greedy payout of 5 from 5+5 stock");
      repeat (5) applyStimulus(0, 4'd0, 0, 1, 1);
      checkOutput("refilled_florins", int'(florinCount), 5);
      runTxn(4'd5, fCyc, sCyc, doneCnt);
      checkOutput("florin_strobe_cycles", fCyc, 8);
      checkOutput("shilling_strobe_cycles", sCyc, 4);
      checkOutput("done_pulses", doneCnt, 1);
      checkOutput("paid_remaining", int'(remaining), 0);
      checkOutput("paid_florins", int'(florinCount), 3);
      checkOutput("paid_shillings", int'(shillingCount), 4);
      checkOutput("paid_short", int'(shortChange), 0);

      $display("[TB] shortfall with 0 florins and 2 shillings");
      doReset();
      repeat (2) applyStimulus(0, 4'd0, 0, 0, 1);
      runTxn(4'd5, fCyc, sCyc, doneCnt);
      checkOutput("short_shilling_cycles", sCyc, 8);
      checkOutput("short_florin_cycles", fCyc, 0);
      checkOutput("short_flag", int'(shortChange), 1);
      checkOutput("short_remaining", int'(remaining), 3);

      $display("[TB] zero amount request");
      applyStimulus(1, 4'd0, 0, 0, 0);
      checkOutput("zero_ack", int'(changeAck), 1);
      checkOutput("zero_short_cleared", int'(shortChange), 0);
      applyStimulus(0, 4'd0, 0, 0, 0);
      checkOutput("zero_done", int'(done), 1);
      checkOutput("zero_no_strobe", int'(florinChange | shillingChange), 0);
      applyStimulus(0, 4'd0, 0, 0, 0);
      checkOutput("zero_idle", int'(busy), 0);

      $display("[TB] eject_done during strobe, refill colliding with dispense");
      doReset();
      repeat (3) applyStimulus(0, 4'd0, 0, 1, 0);
      applyStimulus(1, 4'd2, 0, 0, 0);
      applyStimulus(0, 4'd0, 1, 0, 0);
      applyStimulus(0, 4'd0, 1, 0, 0);
      checkOutput("strobe_mid_high", int'(florinChange), 1);
      checkOutput("strobe_mid_remaining", int'(remaining), 2);
      repeat (3) applyStimulus(0, 4'd0, 1, 0, 0);
      checkOutput("wait_strobe_low", int'(florinChange), 0);
      checkOutput("wait_remaining", int'(remaining), 2);
      applyStimulus(0, 4'd0, 1, 1, 0);
      checkOutput("net_florins", int'(florinCount), 3);
      checkOutput("net_remaining", int'(remaining), 0);
      applyStimulus(0, 4'd0, 0, 0, 0);
      applyStimulus(0, 4'd0, 0, 0, 0);
      checkOutput("net_idle", int'(busy), 0);
      repeat (14) applyStimulus(0, 4'd0, 0, 1, 0);
      checkOutput("saturated_florins", int'(florinCount), 15);

      $display("[TB] hopper timeout");
      applyStimulus(1, 4'd2, 0, 0, 0);
      cyc = 0; seen = 0;
      for (int i = 0; i < 1200 && !seen; i++) begin
         applyStimulus(0, 4'd0, 0, 0, 0);
         cyc++;
         if (fault) seen = 1;
      end
      checkOutput("fault_seen", int'(seen), 1);
      checkOutput("fault_latency", cyc, 5 + TIMEOUT);
      checkOutput("fault_strobes", int'(florinChange | shillingChange), 0);
      checkOutput("fault_busy", int'(busy), 1);
      repeat (3) begin
         applyStimulus(1, 4'd3, 0, 0, 0);
         checkOutput("fault_no_ack", int'(changeAck), 0);
      end
      doReset();
      checkOutput("fault_cleared", int'(fault), 0);
      checkOutput("fault_stock_lost", int'(florinCount), 0);

      $display("[TB] reset mid-strobe");
      repeat (2) applyStimulus(0, 4'd0, 0, 1, 0);
      applyStimulus(1, 4'd2, 0, 0, 0);
      applyStimulus(0, 4'd0, 0, 0, 0);
      applyStimulus(0, 4'd0, 0, 0, 0);
      checkOutput("pre_reset_strobe", int'(florinChange), 1);
      rstN = 1'b0;
      applyStimulus(0, 4'd0, 0, 0, 0);
      checkOutput("post_reset_strobe", int'(florinChange), 0);
      checkOutput("post_reset_busy", int'(busy), 0);
      checkOutput("post_reset_remaining", int'(remaining), 0);
      checkOutput("post_reset_florins", int'(florinCount), 0);
      rstN = 1'b1;

      $display("[TB] randomized soak");
      rate = 2;
      for (int i = 0; i < 3000; i++) begin
         if (i % 500 == 0) rate = $urandom_range(0, 5);
         applyStimulus(logic'($urandom_range(0, 3) == 0),
                       4'($urandom_range(0, 15)),
                       logic'($urandom_range(0, 2) == 0),
                       logic'($urandom_range(0, 15) < rate),
                       logic'($urandom_range(0, 15) < rate));
      end
      applyStimulus(0, 4'd0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/change_dispenser_ctrl.md
# change_dispenser_ctrl

Sequencer for the change-return path of the vending machine. It accepts a change amount in shillings and drives the florin and shilling eject solenoids one coin at a time, greedy florin-first, with a completion handshake from the hopper sensor per coin. It also tracks per-denomination coin inventory, reports shortfall when exact change cannot be paid, and latches a fault on a stuck hopper. It sits between the state/decision logic that computes change and the coin hopper outputs (`florin_Change`, `shilling_Change`).

## Interface
- `PULSE_CYCLES`, 4: cycles each eject strobe is held high (≥1).
- `TIMEOUT_CYCLES`, 1000: max cycles waiting for `eject_done` before fault (≥2).
- `COIN_MAX`, 15: inventory saturation limit per denomination.
- `clock_50MHz` in 1: system clock, all logic rising-edge.
- `sync_Reset_n` in 1: synchronous, active-low reset.
- `change_req` in 1: request; sampled only in IDLE.
- `change_amount` in 4: change owed in shillings, 0–15, valid with `change_req`.
- `eject_done` in 1: hopper sensor, coin has dropped.
- `refill_florin` in 1: +1 florin inventory per high cycle.
- `refill_shilling` in 1: +1 shilling inventory per high cycle.
- `change_ack` out 1: one-cycle pulse, request accepted.
- `florin_Change` out 1: florin eject strobe.
- `shilling_Change` out 1: shilling eject strobe.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at end of transaction.
- `short_change` out 1: transaction ended with `remaining` > 0. Holds until the next `change_ack`.
- `fault` out 1: hopper timeout. Sticky until reset.
- `remaining` out 4: shillings still owed.
- `florin_count` out $clog2(COIN_MAX+1): florin inventory.
- `shilling_count` out $clog2(COIN_MAX+1): shilling inventory.

## Operation
- **States:** IDLE, PLAN, EJECT_F, EJECT_S, WAIT, DONE, FAULT.
- **IDLE:**
  - On `change_req`, latch `change_amount` into `remaining` and go to PLAN.
  - `change_ack` is high during the first PLAN cycle.
  - `short_change` clears with `change_ack`.
- **PLAN (one cycle), in priority order:**
  - `remaining` = 0 → DONE.
  - `remaining` ≥ 2 and `florin_count` > 0 → EJECT_F.
  - `remaining` ≥ 1 and `shilling_count` > 0 → EJECT_S.
  - Otherwise → DONE with `short_change` = 1.
- **EJECT_F / EJECT_S:**
  - The matching strobe is high for exactly `PULSE_CYCLES` cycles, then the state moves to WAIT.
  - `eject_done` is ignored during EJECT_F / EJECT_S.
- **WAIT:**
  - On `eject_done`, decrement `remaining` by the coin value (florin 2, shilling 1) and decrement that inventory by 1, then go to PLAN.
  - A wait counter starts at 0 on entry. If it reaches `TIMEOUT_CYCLES` with no `eject_done`, go to FAULT.
- **DONE:** `done` is high for one cycle, then the state returns to IDLE.
- **FAULT:**
  - Strobes are 0 and `busy` = 1.
  - Requests are not acknowledged.
  - The only exit is reset.
- **Inventory:**
  - Refill and dispense-decrement in the same cycle net to no change.
  - Refill saturates at `COIN_MAX`.
  - Decrement never occurs at 0, because PLAN guarantees the stock was present.
  - Refills are accepted in every state.
- `change_req` while busy is ignored, with no queueing. The requester holds it until `change_ack`.
- `remaining` never underflows: a florin is only selected when `remaining` ≥ 2.

## Timing
- **Reset values:**
  - State = IDLE.
  - `remaining`, `florin_count`, `shilling_count` = 0.
  - `change_ack`, strobes, `busy`, `done`, `short_change`, `fault` = 0.
- **Reset mid-transaction:** reset has priority everywhere. Strobes drop the cycle after reset is sampled, and inventory is lost. Reload via refill.
- **Request timing:**
  - `change_req` sampled at edge N in IDLE gives `change_ack` and `busy` high in cycle N+1 (PLAN).
  - The first strobe rises in cycle N+2.
- **Coin timing:** `eject_done` sampled in WAIT at edge M gives updated `remaining` and inventory in M+1 (PLAN). The next strobe or DONE follows in M+2.
- **Zero amount:** `change_amount` = 0 gives ack in N+1, `done` in N+2, and IDLE in N+3.
- **Outputs:** all are registered, with no combinational input-to-output paths.

## Structure
- **Shared package `vending_pkg`:**
  - State enum `chg_state_t`.
  - Constants `FLORIN_VALUE` = 2 and `SHILLING_VALUE` = 1.
  - Amount width `CHANGE_W` = 4.
- **Sub-module `coin_inventory`:**
  - Saturating up/down counter with inc, dec and count.
  - Parameterised by `COIN_MAX`.
  - Instantiated twice, once for florins and once for shillings.
- **Top level:** FSM, pulse counter and timeout counter.

## Test plan
- 5 florins + 5 shillings refilled, request 5 → florin, florin, shilling strobes, each high 4 cycles. Ends with `remaining` 0, counts 3/4, one `done` pulse, `short_change` = 0.
- 0 florins + 2 shillings, request 5 → two shilling strobes, then `done` with `short_change` = 1 and `remaining` = 3.
- Request 0 → `change_ack` at N+1, `done` at N+2, no strobes.
- `eject_done` withheld for 1000 cycles in WAIT → `fault` = 1, strobes 0. A later `change_req` gets no ack. Reset clears everything.
- `refill_florin` and `eject_done` (florin) in the same cycle with count 3 → count stays 3. Refill at count 15 stays 15.
- `eject_done` pulsed during EJECT_F → ignored; `remaining` is unchanged until a WAIT-phase `eject_done`. Reset asserted mid-strobe → strobe low next cycle, all outputs at reset values.
